// File: rtl/hdmi_crc_pkg.sv
// Shared CRC-32 constants and the per-pixel update function for the HDMI capture path.
package hdmi_crc_pkg;

    localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

    // Reflected CRC-32 over one 24-bit pixel: bytes [7:0], [15:8], [23:16], each LSB first.
    function automatic logic [31:0] crc32_upd24(input logic [31:0] c, input logic [23:0] px);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 24; i++) begin
            fb = r[0] ^ px[i];
            r  = {1'b0, r[31:1]};
            if (fb) begin
                r = r ^ CRC32_POLY;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hdmi_stream_crc_sink_crc32_px24.sv
// Registered CRC-32 accumulator, one 24-bit pixel per enabled cycle.
module crc32_px24
    import hdmi_crc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [23:0] px,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    // Next CRC: restart from the seed when init is set, otherwise continue the running value.
    always_comb begin
        crc_d = crc_q;
        if (en) begin
            crc_d = crc32_upd24(init ? CRC32_INIT : crc_q, px);
        end
    end

    // CRC state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= CRC32_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/hdmi_stream_crc_sink.sv
// AXI-Stream video sink: accepts 24-bit pixels, checks frame geometry,
// computes a per-frame CRC-32 and exposes counters and sticky error flags.
module hdmi_stream_crc_sink
    import hdmi_crc_pkg::*;
#(
    parameter int FRAME_WIDTH  = 32,
    parameter int FRAME_HEIGHT = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        s_axis_tready,
    input  logic        stall,
    input  logic        clear,
    output logic [31:0] beat_count,
    output logic [31:0] frame_count,
    output logic [15:0] drop_count,
    output logic [31:0] crc_last,
    output logic        crc_done,
    output logic [15:0] line_count,
    output logic [15:0] pixel_in_line,
    output logic [2:0]  err_flags
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [15:0] W_LAST = 16'(FRAME_WIDTH - 1);
    localparam logic [15:0] W_FULL = 16'(FRAME_WIDTH);
    localparam logic [15:0] H_LAST = 16'(FRAME_HEIGHT - 1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] beat_q, beat_d;
    logic [31:0] frame_q, frame_d;
    logic [15:0] drop_q, drop_d;
    logic [31:0] crc_last_q, crc_last_d;
    logic        done_q, done_d;
    logic [15:0] line_q, line_d;
    logic [15:0] pix_q, pix_d;
    logic [2:0]  err_q, err_d;
    logic        fend_q, fend_d;

    logic        beat;
    logic [15:0] pix_cur, line_cur, pix_nxt;
    logic        crc_en, crc_init;
    logic [31:0] crc_run;

    // Ready depends only on the stall injection, never on tvalid.
    assign s_axis_tready = ~stall;
    assign beat          = s_axis_tvalid & ~stall;

    // A SOF beat always starts from pixel 0 of line 0, whichever state it arrives in.
    assign pix_cur  = s_axis_tuser ? 16'd0 : pix_q;
    assign line_cur = s_axis_tuser ? 16'd0 : line_q;
    assign pix_nxt  = sat_inc16(pix_cur);

    crc32_px24 u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (crc_init),
        .en   (crc_en),
        .px   (s_axis_tdata),
        .crc  (crc_run)
    );

    // Frame tracking, geometry checks and counter updates.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        frame_d    = frame_q;
        drop_d     = drop_q;
        crc_last_d = crc_last_q;
        done_d     = 1'b0;
        line_d     = line_q;
        pix_d      = pix_q;
        err_d      = err_q;
        fend_d     = 1'b0;
        crc_en     = 1'b0;
        crc_init   = 1'b0;
        if (clear) begin
            state_d    = IDLE;
            beat_d     = '0;
            frame_d    = '0;
            drop_d     = '0;
            crc_last_d = '0;
            line_d     = '0;
            pix_d      = '0;
            err_d      = '0;
        end else begin
            // The frame-end beat already folded its pixel into crc_run; publish it one cycle later.
            if (fend_q) begin
                crc_last_d = crc_run ^ CRC32_XOROUT;
                frame_d    = frame_q + 32'd1;
                done_d     = 1'b1;
            end
            if (beat) begin
                beat_d = beat_q + 32'd1;
                if (state_q == IDLE && !s_axis_tuser) begin
                    drop_d = sat_inc16(drop_q);
                end else begin
                    crc_en   = 1'b1;
                    crc_init = s_axis_tuser;
                    if (s_axis_tuser && state_q == ACTIVE) begin
                        err_d[2] = 1'b1;
                    end
                    if (s_axis_tlast) begin
                        if (pix_cur < W_LAST) err_d[0] = 1'b1;
                        if (pix_cur > W_LAST) err_d[1] = 1'b1;
                        pix_d = '0;
                        if (line_cur == H_LAST) begin
                            line_d  = '0;
                            state_d = IDLE;
                            fend_d  = 1'b1;
                        end else begin
                            line_d  = line_cur + 16'd1;
                            state_d = ACTIVE;
                        end
                    end else begin
                        pix_d   = pix_nxt;
                        line_d  = line_cur;
                        state_d = ACTIVE;
                        if (pix_nxt >= W_FULL) err_d[1] = 1'b1;
                    end
                end
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            frame_q    <= '0;
            drop_q     <= '0;
            crc_last_q <= '0;
            done_q     <= 1'b0;
            line_q     <= '0;
            pix_q      <= '0;
            err_q      <= '0;
            fend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            frame_q    <= frame_d;
            drop_q     <= drop_d;
            crc_last_q <= crc_last_d;
            done_q     <= done_d;
            line_q     <= line_d;
            pix_q      <= pix_d;
            err_q      <= err_d;
            fend_q     <= fend_d;
        end
    end

    assign beat_count    = beat_q;
    assign frame_count   = frame_q;
    assign drop_count    = drop_q;
    assign crc_last      = crc_last_q;
    assign crc_done      = done_q;
    assign line_count    = line_q;
    assign pixel_in_line = pix_q;
    assign err_flags     = err_q;

endmodule
